// File: rtl/uart_pkg.sv
// Shared UART definitions: word geometry and the packer byte-index type.
package uart_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  // Byte position within the word being assembled; doubles as packer state.
  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2,
    B3 = 2'd3
  } byte_idx_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head output.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     not_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     push_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_fire;

  // Pop only counts while something is stored; ready on an empty FIFO is ignored.
  assign not_empty = (level != '0);
  assign pop_fire  = pop && not_empty;
  assign push_ok   = push && ((level < LW'(DEPTH)) || pop_fire);

  // Head is gated to zero while empty so the output reads 0 out of reset.
  assign head = not_empty ? mem[rd_ptr] : '0;

  // Storage write; contents need no reset because the head is gated by level.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_fire})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_word_packer.sv
// Packs UART receive bytes into 32-bit words, buffers them in a FIFO and
// reports overrun / framing events as sticky flags.
module uart_word_packer
  import uart_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [7:0]             rdata,
  input  logic                   rdata_ready,
  input  logic                   ferr,
  output logic [WORD_W-1:0]      word,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun,
  output logic                   frame_err,
  input  logic                   err_clr
);

  byte_idx_t         idx;
  logic [1:0]        idx_bits;
  logic [1:0]        lane;
  logic              ferr_q;
  logic              rise;
  logic              strobe;
  logic              word_done;
  logic              push_ok;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] asm_word;

  assign idx_bits  = idx;
  assign rise      = ferr && !ferr_q;
  // A framing rise discards any byte arriving in the same cycle.
  assign strobe    = rdata_ready && !rise;
  // Big-endian mirrors the lane order: 3 - idx is the bitwise inverse for 2 bits.
  assign lane      = BIG_ENDIAN ? ~idx_bits : idx_bits;
  assign word_done = strobe && (idx == B3);

  // Merge the incoming byte into its lane so the completed word is pushable
  // in the same cycle as the 4th strobe.
  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
    assign asm_word[gi*8 +: 8] = (strobe && (lane == 2'(gi))) ? rdata : shreg[gi*8 +: 8];
  end

  // Packer FSM: byte index advances per accepted strobe, framing rise restarts it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx    <= B0;
      ferr_q <= 1'b0;
      shreg  <= '0;
    end else begin
      ferr_q <= ferr;
      shreg  <= asm_word;
      if (rise) begin
        idx <= B0;
      end else if (rdata_ready) begin
        idx <= byte_idx_t'(idx_bits + 2'd1);
      end
    end
  end

  // Sticky error flags; a new event in the clear cycle keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (word_done && !push_ok) || (overrun && !err_clr);
      frame_err <= rise || (frame_err && !err_clr);
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (word_done),
    .push_data (asm_word),
    .pop       (word_ready),
    .head      (word),
    .not_empty (word_valid),
    .level     (level),
    .push_ok   (push_ok)
  );

endmodule

// File: tb/tb_uart_word_packer.sv
// Bench for uart_word_packer: little- and big-endian instances share stimulus
// and are compared every cycle against a queue-based model of the byte stream.
module tb_uart_word_packer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] in_data;
  logic       in_strobe;
  logic       in_ferr;
  logic       in_wready;
  logic       in_clr;

  logic [31:0] le_word, be_word;
  logic        le_valid, be_valid;
  logic [2:0]  le_level, be_level;
  logic        le_ovr, be_ovr, le_fe, be_fe;

  always #5 clk = ~clk;

  uart_word_packer #(.DEPTH(DEPTH), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rstn(rstn), .rdata(in_data), .rdata_ready(in_strobe), .ferr(in_ferr),
    .word(le_word), .word_valid(le_valid), .word_ready(in_wready), .level(le_level),
    .overrun(le_ovr), .frame_err(le_fe), .err_clr(in_clr)
  );

  uart_word_packer #(.DEPTH(DEPTH), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rstn(rstn), .rdata(in_data), .rdata_ready(in_strobe), .ferr(in_ferr),
    .word(be_word), .word_valid(be_valid), .word_ready(in_wready), .level(be_level),
    .overrun(be_ovr), .frame_err(be_fe), .err_clr(in_clr)
  );

  // Model state: pending bytes, queued words for each byte order, flags.
  logic [7:0]  bq[$];
  logic [31:0] qle[$];
  logic [31:0] qbe[$];
  bit          m_ovr, m_fe, m_fq;
  bit          ferr_lvl;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    qle.delete();
    qbe.delete();
    m_ovr = 0;
    m_fe  = 0;
    m_fq  = 0;
  endtask

  // One clock edge of the byte-stream model, using the inputs seen at that edge.
  task automatic model_update();
    bit pop, rise, done, full, ovr_set;
    logic [31:0] wl, wb;
    pop  = in_wready && (qle.size() > 0);
    rise = in_ferr && !m_fq;
    m_fq = in_ferr;
    done = 0;
    wl = '0;
    wb = '0;
    if (rise) begin
      bq.delete();
    end else if (in_strobe) begin
      bq.push_back(in_data);
      if (bq.size() == 4) begin
        wl = {bq[3], bq[2], bq[1], bq[0]};
        wb = {bq[0], bq[1], bq[2], bq[3]};
        done = 1;
        bq.delete();
      end
    end
    full = (qle.size() >= DEPTH);
    if (pop) begin
      $display("pop le=%h be=%h", qle[0], qbe[0]);
      void'(qle.pop_front());
      void'(qbe.pop_front());
    end
    ovr_set = done && full && !pop;
    if (done && !ovr_set) begin
      qle.push_back(wl);
      qbe.push_back(wb);
    end
    m_ovr = ovr_set || (m_ovr && !in_clr);
    m_fe  = rise || (m_fe && !in_clr);
  endtask

  task automatic compare_all();
    int n;
    n = qle.size();
    chk("le_valid", {31'd0, le_valid}, {31'd0, n > 0});
    chk("be_valid", {31'd0, be_valid}, {31'd0, n > 0});
    chk("le_level", {29'd0, le_level}, n);
    chk("be_level", {29'd0, be_level}, n);
    chk("le_overrun", {31'd0, le_ovr}, {31'd0, m_ovr});
    chk("be_overrun", {31'd0, be_ovr}, {31'd0, m_ovr});
    chk("le_frame_err", {31'd0, le_fe}, {31'd0, m_fe});
    chk("be_frame_err", {31'd0, be_fe}, {31'd0, m_fe});
    if (n > 0) begin
      chk("le_word", le_word, qle[0]);
      chk("be_word", be_word, qbe[0]);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, then check.
  task automatic step(input bit s, input logic [7:0] d, input bit f, input bit wr, input bit clr);
    in_strobe = s;
    in_data   = d;
    in_ferr   = f;
    in_wready = wr;
    in_clr    = clr;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_word(input logic [31:0] w, input bit wr_last);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, w[8*i +: 8], ferr_lvl, (i == 3) ? wr_last : 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input bit wr);
    step(1'b0, 8'h00, ferr_lvl, wr, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_word"},  le_word | be_word, 32'h0);
    chk({tag, "_valid"}, {30'd0, le_valid, be_valid}, 32'h0);
    chk({tag, "_level"}, {26'd0, le_level, be_level}, 32'h0);
    chk({tag, "_flags"}, {28'd0, le_ovr, be_ovr, le_fe, be_fe}, 32'h0);
  endtask

  initial begin
    rstn = 1'b0;
    in_data = 8'h00; in_strobe = 1'b0; in_ferr = 1'b0; in_wready = 1'b0; in_clr = 1'b0;
    ferr_lvl = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rstn = 1'b1;

    // Basic packing, back-to-back strobes, both byte orders.
    send_word(32'h12345678, 1'b0);
    chk("t1_le_word", le_word, 32'h12345678);
    chk("t1_be_word", be_word, 32'h78563412);
    chk("t1_level", {29'd0, le_level}, 32'd1);
    idle(1'b1);

    // Overflow: fifth word is dropped and flagged.
    for (int k = 1; k <= 5; k++) send_word(32'h11111111 * k, 1'b0);
    chk("ovf_level", {29'd0, le_level}, 32'd4);
    chk("ovf_flag", {31'd0, le_ovr}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_drain", le_word, 32'h11111111 * (k + 1));
      idle(1'b1);
    end
    chk("ovf_empty", {31'd0, le_valid}, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_ovr", {31'd0, le_ovr}, 32'd0);

    // Full FIFO with a pop in the same cycle as the completing strobe.
    for (int k = 0; k < 4; k++) send_word($urandom, 1'b0);
    send_word(32'hCAFEF00D, 1'b1);
    chk("fullpop_ovr", {31'd0, le_ovr}, 32'd0);
    chk("fullpop_level", {29'd0, le_level}, 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) chk("fullpop_last", le_word, 32'hCAFEF00D);
      idle(1'b1);
    end

    // Framing rise discards the partial word; held ferr has no further effect.
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
    ferr_lvl = 1;
    idle(1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    chk("ferr_flag", {31'd0, le_fe}, 32'd1);
    chk("ferr_le_word", le_word, 32'hDEADBEEF);
    chk("ferr_be_word", be_word, 32'hEFBEADDE);
    idle(1'b1);
    ferr_lvl = 0;
    idle(1'b0);
    // Rise coincident with a strobe: that byte is lost too.
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    send_word(32'h01020304, 1'b0);
    chk("rise_strobe_word", le_word, 32'h01020304);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("clr_flags", {30'd0, le_ovr, le_fe}, 32'd0);

    // Asynchronous reset with two words queued and three bytes pending.
    send_word(32'hA5A5A5A5, 1'b0);
    send_word(32'h5A5A5A5A, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_level", {29'd0, le_level}, 32'd2);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    send_word(32'hFEEDC0DE, 1'b0);
    chk("post_rst_word", le_word, 32'hFEEDC0DE);
    chk("post_rst_level", {29'd0, le_level}, 32'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3) ferr_lvl = ~ferr_lvl;
      step($urandom_range(0, 1) == 1, 8'($urandom), ferr_lvl,
           $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_word_packer.md
# uart_word_packer

Receive-side packer directly downstream of the UART byte receiver. It consumes the receiver's one-cycle byte strobes and assembles every four consecutive bytes into a 32-bit word. Completed words are buffered in a small FIFO and presented to the core-side loader and input path over a valid/ready handshake. Overrun and framing events are reported as sticky flags.

## Interface
- `DEPTH`, default 4: FIFO depth in 32-bit words; power of two, ≥2.
- `BIG_ENDIAN`, default 0: 0 places the first byte in [7:0]; 1 places the first byte in [31:24].

- `clk`  in  1  system clock.
- `rstn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `rdata`  in  8  received byte; valid only while `rdata_ready`=1.
- `rdata_ready`  in  1  one-cycle byte strobe from the receiver.
- `ferr`  in  1  receiver framing-error level; sticky upstream.
- `word`  out  32  FIFO head word; valid only while `word_valid`=1.
- `word_valid`  out  1  FIFO non-empty.
- `word_ready`  in  1  consumer accepts the head word when `word_valid`&&`word_ready`.
- `level`  out  $clog2(DEPTH)+1  number of words currently in the FIFO.
- `overrun`  out  1  sticky; a completed word was dropped because the FIFO was full.
- `frame_err`  out  1  sticky; a rising edge was seen on `ferr`.
- `err_clr`  in  1  synchronous pulse; clears `overrun` and `frame_err`.

## Operation
- Reset values: `word`=0, `word_valid`=0, `level`=0, `overrun`=0, `frame_err`=0. The byte index, shift register, FIFO pointers, and registered copy of `ferr` are all 0.
- Packer FSM: the 2-bit byte index forms the states B0→B1→B2→B3→B0. Each `rdata_ready` pulse writes `rdata` into lane idx (or lane 3−idx when `BIG_ENDIAN`=1) and advances idx.
- On a strobe in B3, the completed word goes into the FIFO and idx returns to B0. The other lanes are not cleared; they are overwritten on the next word.
- `ferr` edge detection: rise = `ferr` && !`ferr_q`. On a rise:
  - idx → B0, discarding the partial word;
  - `frame_err` ← 1.
- If a rise and a strobe occur in the same cycle, the byte is discarded as well.
- Push rule: a completed word is accepted when level<DEPTH, or when a pop occurs in the same cycle. Otherwise the word is dropped, `overrun` ← 1, and FIFO contents are unchanged.
- Pop: `word_valid`&&`word_ready`. Pointers wrap modulo DEPTH. Level is updated as +1 for push only, −1 for pop only, and unchanged when both occur.
- `err_clr` in the same cycle as a new overrun or rise: the set wins.
- `word_ready` is ignored while `word_valid`=0.

## Timing
- Byte strobe → index update takes 1 cycle.
- For the 4th strobe at cycle t, the word is written at the edge ending t. With the FIFO previously empty, `word_valid`=1 and `word`=new value in cycle t+1.
- Strobes are at least 1 cycle apart by construction; back-to-back strobes on consecutive cycles must still be handled correctly.
- `word`/`word_valid` are registered or FIFO-head reads with no combinational path from `word_ready`. After a pop at cycle t, the next head is visible in t+1.
- Full throughput: one pop per cycle while non-empty.
- Asynchronous reset mid-word or mid-FIFO: everything returns to reset values immediately, and the partial word is lost. The first strobe after release is byte 0.

## Structure
- Shared package `uart_pkg`: `WORD_W`=32, `BYTES_PER_WORD`=4, and the byte-index typedef.
- Sub-module `sync_fifo #(WIDTH, DEPTH)` provides the storage, pointers, level, and the push-when-full-with-pop rule. It is reusable by the transmit side.
- The top level holds the packer FSM, edge detector, and sticky flags.

## Test plan
- Strobe 0x78, 0x56, 0x34, 0x12 with `word_ready`=0 → `word`=0x12345678, `word_valid`=1 one cycle after the 4th strobe, `level`=1. With `BIG_ENDIAN`=1 the same stimulus gives 0x78563412.
- DEPTH=4, `word_ready`=0: push 5 words 0x11111111…0x55555555 → `level`=4 and `overrun`=1 after the 5th. Then draining yields 0x11111111…0x44444444 in order; 0x55555555 is never seen.
- FIFO full with `word_ready`=1 in the same cycle as the 4th strobe of a new word → no overrun, `level` stays 4, and the new word appears last in the drain order.
- Strobe 2 bytes, raise `ferr`, then strobe 0xEF, 0xBE, 0xAD, 0xDE → `frame_err`=1 and `word`=0xDEADBEEF. `ferr` held high afterwards causes no further effect.
- Pulse `err_clr` → both flags return to 0.
- Assert `rstn`=0 asynchronously after 3 bytes with 2 words queued → all outputs return to reset values without a clock edge. After release, 4 new bytes form a clean word.
